// File: rtl/fade_pkg.sv
// Shared types and constants for the fading-channel frame scheduler.
package fade_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        HOLD  = 2'd3
    } fseq_state_t;

    localparam int FADE_M          = 8;
    localparam int FADE_N          = 32;
    localparam int FADE_TW         = 25;
    localparam int FADE_MIN_PERIOD = FADE_M * FADE_N + 16;

endpackage

// File: rtl/fade_rx_check.sv
// Tracks the fader output stream: channel order, per-frame count, frame completion and sequence errors.
module fade_rx_check
    import fade_pkg::*;
#(
    parameter int N = FADE_N
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        clr_cnt,
    input  logic        in_run,
    input  logic        clr_status,
    input  logic        dv,
    input  logic [4:0]  chan,
    output logic        rx_last,
    output logic        frame_done,
    output logic        seq_err,
    output logic [15:0] frame_count
);

    localparam int CW = $clog2(N + 1);

    logic [CW-1:0] rx_cnt;
    logic [4:0]    exp_chan;
    logic          err_set;

    // The fader walks channels downward, so the N-th output carries channel 0.
    assign rx_last = in_run && dv && (rx_cnt == CW'(N - 1));
    assign err_set = dv && (!in_run || (chan != exp_chan));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_cnt      <= '0;
            exp_chan    <= 5'(N - 1);
            frame_done  <= 1'b0;
            seq_err     <= 1'b0;
            frame_count <= '0;
        end else begin
            if (clr_cnt) begin
                rx_cnt   <= '0;
                exp_chan <= 5'(N - 1);
            end else if (in_run && dv) begin
                rx_cnt   <= rx_cnt + 1'b1;
                exp_chan <= exp_chan - 1'b1;
            end

            frame_done <= rx_last;

            if (err_set)
                seq_err <= 1'b1;
            else if (clr_status)
                seq_err <= 1'b0;

            if (clr_status)
                frame_count <= '0;
            else if (rx_last)
                frame_count <= frame_count + 16'd1;
        end
    end

endmodule

// File: rtl/fade_sequencer.sv
// Frame scheduler: issues periodic fader starts with an advancing time index and supervises each sweep.
//
//   state | meaning
//   IDLE  | waiting for enable
//   START | one-cycle start pulse, time index latched, period counter loaded
//   RUN   | collecting the N fader outputs of this frame
//   HOLD  | frame complete, waiting out the rest of the period
module fade_sequencer
    import fade_pkg::*;
#(
    parameter int M          = FADE_M,
    parameter int N          = FADE_N,
    parameter int TW         = FADE_TW,
    parameter int PW         = 16,
    parameter int MIN_PERIOD = M * N + 16
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          enable,
    input  logic [PW-1:0] period,
    input  logic [TW-1:0] t_step,
    input  logic          load_t,
    input  logic [TW-1:0] t_load_val,
    input  logic          clr_status,
    output logic          fader_start,
    output logic [TW-1:0] fader_t_index,
    input  logic          fader_dv,
    input  logic [4:0]    fader_chan,
    output logic          frame_done,
    output logic [15:0]   frame_count,
    output logic          timeout,
    output logic          seq_err,
    output logic          busy
);

    fseq_state_t   state_q, state_d, rearm;
    logic [PW-1:0] cnt;
    logic [PW-1:0] p_eff;
    logic [TW-1:0] t_cur;
    logic [TW-1:0] t_idx_q;
    logic [TW-1:0] start_val;
    logic          tc;
    logic          timeout_set;
    logic          rx_last;
    logic          in_start;
    logic          in_run;

    assign in_start  = (state_q == START);
    assign in_run    = (state_q == RUN);
    assign p_eff     = (period < PW'(MIN_PERIOD)) ? PW'(MIN_PERIOD) : period;
    // Counter is loaded with P-1 in START; expiring at 1 puts the next START exactly P cycles later.
    assign tc        = (cnt == PW'(1));
    assign start_val = load_t ? t_load_val : t_cur;
    assign rearm     = enable ? START : IDLE;

    assign fader_start   = in_start;
    assign fader_t_index = in_start ? start_val : t_idx_q;
    assign busy          = (state_q != IDLE);

    always_comb begin
        state_d     = state_q;
        timeout_set = 1'b0;
        unique case (state_q)
            IDLE:  if (enable) state_d = START;
            START: state_d = RUN;
            RUN: begin
                if (rx_last) begin
                    state_d = tc ? rearm : HOLD;
                end else if (tc) begin
                    timeout_set = 1'b1;
                    state_d     = rearm;
                end
            end
            HOLD:  if (tc) state_d = rearm;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt     <= '0;
            t_cur   <= '0;
            t_idx_q <= '0;
            timeout <= 1'b0;
        end else begin
            state_q <= state_d;

            if (in_start) begin
                cnt     <= p_eff - 1'b1;
                t_cur   <= start_val + t_step;
                t_idx_q <= start_val;
            end else begin
                if (load_t)
                    t_cur <= t_load_val;
                if ((state_q == RUN || state_q == HOLD) && cnt != '0)
                    cnt <= cnt - 1'b1;
            end

            if (timeout_set)
                timeout <= 1'b1;
            else if (clr_status)
                timeout <= 1'b0;
        end
    end

    fade_rx_check #(.N(N)) u_rx_check (
        .clk         (clk),
        .resetn      (resetn),
        .clr_cnt     (in_start),
        .in_run      (in_run),
        .clr_status  (clr_status),
        .dv          (fader_dv),
        .chan        (fader_chan),
        .rx_last     (rx_last),
        .frame_done  (frame_done),
        .seq_err     (seq_err),
        .frame_count (frame_count)
    );

endmodule

// File: tb/tb_fade_sequencer.sv
// Bench for fade_sequencer with a behavioural fader model and a start/time-index scoreboard.
module tb_fade_sequencer;

    localparam int M   = 8;
    localparam int N   = 32;
    localparam int LAT = 4;

    localparam int MODE_NORMAL = 0;
    localparam int MODE_SHORT  = 1;
    localparam int MODE_BAD    = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        enable;
    logic [15:0] period;
    logic [24:0] t_step;
    logic        load_t;
    logic [24:0] t_load_val;
    logic        clr_status;
    logic        fader_start;
    logic [24:0] fader_t_index;
    logic        fader_dv;
    logic [4:0]  fader_chan;
    logic        frame_done;
    logic [15:0] frame_count;
    logic        timeout;
    logic        seq_err;
    logic        busy;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int n_starts = 0;
    int n_done   = 0;
    int last_dv_cyc = 0;
    int mode = MODE_NORMAL;
    int m_k  = 0;
    bit m_act = 1'b0;
    logic [24:0] exp_q[$];

    fade_sequencer dut (
        .clk           (clk),
        .resetn        (resetn),
        .enable        (enable),
        .period        (period),
        .t_step        (t_step),
        .load_t        (load_t),
        .t_load_val    (t_load_val),
        .clr_status    (clr_status),
        .fader_start   (fader_start),
        .fader_t_index (fader_t_index),
        .fader_dv      (fader_dv),
        .fader_chan    (fader_chan),
        .frame_done    (frame_done),
        .frame_count   (frame_count),
        .timeout       (timeout),
        .seq_err       (seq_err),
        .busy          (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Scoreboard monitor first, then the fader model, all on the falling edge.
    always @(negedge clk) begin
        logic [24:0] e;
        int idx;
        int ndv;
        if (!resetn) begin
            m_act    = 1'b0;
            fader_dv = 1'b0;
        end else begin
            if (fader_start === 1'b1) begin
                n_starts++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL start_unexpected: start at cycle %0d with t_index %h, none expected", cyc, fader_t_index);
                end else begin
                    e = exp_q.pop_front();
                    if (fader_t_index !== e) begin
                        n_fail++;
                        $display("FAIL start_t_index: got %h expected %h at cycle %0d", fader_t_index, e, cyc);
                    end
                end
            end
            if (frame_done === 1'b1) begin
                n_done++;
                n_cmp++;
                if (cyc - last_dv_cyc !== 1) begin
                    n_fail++;
                    $display("FAIL frame_done_latency: got %0d cycles after last dv expected 1", cyc - last_dv_cyc);
                end
            end

            fader_dv = 1'b0;
            if (fader_start === 1'b1) begin
                m_act = 1'b1;
                m_k   = 0;
            end else if (m_act) begin
                m_k++;
                ndv = (mode == MODE_SHORT) ? N - 1 : N;
                if (m_k >= LAT && (m_k - LAT) % M == 0) begin
                    idx = (m_k - LAT) / M;
                    if (idx < ndv) begin
                        fader_dv    = 1'b1;
                        fader_chan  = (mode == MODE_BAD && idx == 2) ? 5'd28 : 5'(N - 1 - idx);
                        last_dv_cyc = cyc;
                    end else begin
                        m_act = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_start(input int budget, output int c);
        c = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (fader_start === 1'b1) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wait_start: got no start within %0d cycles expected one", budget);
        end
    endtask

    task automatic wait_idle(input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wait_idle: busy still %b after %0d cycles expected 0", busy, budget);
        end
    endtask

    task automatic wait_done(input int target, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (n_done >= target) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wait_done: got %0d frame_done pulses expected %0d", n_done, target);
        end
    endtask

    task automatic pulse_clr();
        @(negedge clk) clr_status = 1'b1;
        @(negedge clk) clr_status = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; enable = 1'b0; period = 16'd300; t_step = '0;
        load_t = 1'b0; t_load_val = '0; clr_status = 1'b0;
        fader_dv = 1'b0; fader_chan = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({fader_start, fader_t_index, frame_done, frame_count, timeout, seq_err, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got start=%b t=%h done=%b cnt=%0d to=%b se=%b busy=%b expected all 0",
                     fader_start, fader_t_index, frame_done, frame_count, timeout, seq_err, busy);
        end
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || fader_start !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got busy=%b start=%b expected 0 0", busy, fader_start);
        end
    endtask

    task automatic test_basic_and_enable_drop();
        int c0, c1, c2, c3, s;
        period = 16'd300; t_step = 25'd5; mode = MODE_NORMAL;
        exp_q.push_back(25'd0); exp_q.push_back(25'd5); exp_q.push_back(25'd10);
        @(negedge clk) enable = 1'b1;
        c0 = cyc;
        wait_start(10, c1);
        n_cmp++;
        if (c1 - c0 !== 1) begin
            n_fail++;
            $display("FAIL enable_to_start: got %0d cycles expected 1", c1 - c0);
        end
        wait_start(400, c2);
        n_cmp++;
        if (c2 - c1 !== 300) begin
            n_fail++;
            $display("FAIL start_spacing_300a: got %0d expected 300", c2 - c1);
        end
        wait_start(400, c3);
        n_cmp++;
        if (c3 - c2 !== 300) begin
            n_fail++;
            $display("FAIL start_spacing_300b: got %0d expected 300", c3 - c2);
        end
        enable = 1'b0;
        wait_done(3, 400);
        n_cmp++;
        if (frame_count !== 16'd3 || n_done !== 3) begin
            n_fail++;
            $display("FAIL basic_frame_count: got %0d (pulses %0d) expected 3", frame_count, n_done);
        end
        n_cmp++;
        if (timeout !== 1'b0 || seq_err !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_flags: got timeout=%b seq_err=%b expected 0 0", timeout, seq_err);
        end
        wait_idle(400);
        s = n_starts;
        repeat (50) @(negedge clk);
        n_cmp++;
        if (n_starts !== s || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL enable_drop_no_restart: got starts=%0d busy=%b expected %0d 0", n_starts, busy, s);
        end
    endtask

    task automatic test_clamp();
        int c1, c2;
        period = 16'd100;
        exp_q.push_back(25'd15); exp_q.push_back(25'd20);
        @(negedge clk) enable = 1'b1;
        wait_start(10, c1);
        wait_start(400, c2);
        enable = 1'b0;
        n_cmp++;
        if (c2 - c1 !== 272) begin
            n_fail++;
            $display("FAIL clamp_spacing: got %0d expected 272", c2 - c1);
        end
        wait_idle(400);
        n_cmp++;
        if (frame_count !== 16'd5) begin
            n_fail++;
            $display("FAIL clamp_frame_count: got %0d expected 5", frame_count);
        end
    endtask

    task automatic test_timeout();
        int c1, c2;
        period = 16'd300; mode = MODE_SHORT;
        exp_q.push_back(25'd25); exp_q.push_back(25'd30);
        @(negedge clk) enable = 1'b1;
        wait_start(10, c1);
        wait_start(400, c2);
        mode = MODE_NORMAL;
        enable = 1'b0;
        n_cmp++;
        if (c2 - c1 !== 300) begin
            n_fail++;
            $display("FAIL timeout_spacing: got %0d expected 300", c2 - c1);
        end
        n_cmp++;
        if (timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_flag: got %b expected 1", timeout);
        end
        n_cmp++;
        if (frame_count !== 16'd5) begin
            n_fail++;
            $display("FAIL timeout_frame_count: got %0d expected 5", frame_count);
        end
        wait_idle(400);
        n_cmp++;
        if (frame_count !== 16'd6 || seq_err !== 1'b0) begin
            n_fail++;
            $display("FAIL after_timeout_frame: got count=%0d seq_err=%b expected 6 0", frame_count, seq_err);
        end
        pulse_clr();
        n_cmp++;
        if (timeout !== 1'b0 || frame_count !== 16'd0) begin
            n_fail++;
            $display("FAIL clr_timeout: got timeout=%b count=%0d expected 0 0", timeout, frame_count);
        end
    endtask

    task automatic test_seq_err();
        int c1, d0;
        mode = MODE_BAD;
        exp_q.push_back(25'd35);
        d0 = n_done;
        @(negedge clk) enable = 1'b1;
        wait_start(10, c1);
        enable = 1'b0;
        wait_done(d0 + 1, 400);
        n_cmp++;
        if (seq_err !== 1'b1 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL seq_err_set: got seq_err=%b timeout=%b expected 1 0", seq_err, timeout);
        end
        wait_idle(400);
        pulse_clr();
        n_cmp++;
        if (seq_err !== 1'b0 || frame_count !== 16'd0) begin
            n_fail++;
            $display("FAIL seq_err_clr: got seq_err=%b count=%0d expected 0 0", seq_err, frame_count);
        end
        mode = MODE_NORMAL;
        exp_q.push_back(25'd40);
        @(negedge clk) enable = 1'b1;
        wait_start(10, c1);
        enable = 1'b0;
        wait_idle(400);
        n_cmp++;
        if (seq_err !== 1'b0 || frame_count !== 16'd1) begin
            n_fail++;
            $display("FAIL clean_after_clr: got seq_err=%b count=%0d expected 0 1", seq_err, frame_count);
        end
    endtask

    task automatic test_load_wrap();
        int c1, c2, c3, guard;
        t_step = 25'd3; period = 16'd300;
        exp_q.push_back(25'd45); exp_q.push_back(25'h1FFFFFE); exp_q.push_back(25'h0000001);
        @(negedge clk) enable = 1'b1;
        wait_start(10, c1);
        guard = 0;
        do begin
            @(posedge clk);
            #1;
            guard++;
        end while (cyc != c1 + 300 && guard < 400);
        load_t = 1'b1;
        t_load_val = 25'h1FFFFFE;
        wait_start(3, c2);
        n_cmp++;
        if (c2 !== c1 + 300) begin
            n_fail++;
            $display("FAIL load_start_cycle: got %0d expected %0d", c2, c1 + 300);
        end
        @(posedge clk);
        #1 load_t = 1'b0;
        wait_start(400, c3);
        enable = 1'b0;
        n_cmp++;
        if (c3 - c2 !== 300) begin
            n_fail++;
            $display("FAIL load_next_spacing: got %0d expected 300", c3 - c2);
        end
        wait_idle(400);
    endtask

    task automatic test_reset_mid_frame();
        int c, c_rel;
        exp_q.push_back(25'd4);
        @(negedge clk) enable = 1'b1;
        wait_start(10, c);
        #1 resetn = 1'b0;
        #1;
        n_cmp++;
        if ({fader_start, fader_t_index, frame_done, frame_count, timeout, seq_err, busy} !== '0) begin
            n_fail++;
            $display("FAIL async_reset_outputs: got start=%b t=%h done=%b cnt=%0d to=%b se=%b busy=%b expected all 0",
                     fader_start, fader_t_index, frame_done, frame_count, timeout, seq_err, busy);
        end
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        c_rel = cyc;
        exp_q.push_back(25'd0);
        wait_start(10, c);
        enable = 1'b0;
        n_cmp++;
        if (c - c_rel !== 1) begin
            n_fail++;
            $display("FAIL start_after_reset: got %0d cycles expected 1", c - c_rel);
        end
        wait_idle(400);
    endtask

    initial begin
        test_reset();
        test_basic_and_enable_drop();
        test_clamp();
        test_timeout();
        test_seq_err();
        test_load_wrap();
        test_reset_mid_frame();
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d expected starts left expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fade_sequencer.md
# fade_sequencer

Frame scheduler for the fading-channel generator. It issues the single-cycle `start` pulse and 25-bit time index to the fader at a programmable period, and advances the time index by a programmable step every frame. It watches the fader's `dv_out`/`chan_out` stream to confirm each sweep of N channels completes in order, and reports frame completion, timeouts and sequence errors.

## Interface
Parameters:
- `M`, 8, reflectors per channel (fader sweep length factor)
- `N`, 32, channels per frame
- `TW`, 25, time-index width
- `PW`, 16, period-counter width
- `MIN_PERIOD`, M*N+16 = 272, smallest period honoured; covers sweep plus fader pipeline

Ports:
- `clk` in 1: single clock
- `resetn` in 1: asynchronous, active-low reset
- `enable` in 1: level; run frames while high
- `period` in PW: clocks between starts; sampled at each start
- `t_step` in TW: time-index increment per frame
- `load_t` in 1: pulse; load `t_load_val` as next time index
- `t_load_val` in TW: time-index load value
- `clr_status` in 1: pulse; clear sticky flags and `frame_count`
- `fader_start` out 1: start pulse to fader
- `fader_t_index` out TW: time index to fader; valid and stable from `fader_start` until the next start
- `fader_dv` in 1: fader `dv_out`
- `fader_chan` in 5: fader `chan_out`
- `frame_done` out 1: pulse; N-th output of the frame received
- `frame_count` out 16: completed frames, wraps
- `timeout` out 1: sticky; period expired before N outputs
- `seq_err` out 1: sticky; channel out of order or unexpected dv
- `busy` out 1: FSM not in IDLE

## Operation
- Reset values: all outputs 0. Internal state: `t_cur`=0, FSM=IDLE, `rx_cnt`=0, `exp_chan`=N-1.
- FSM states:
  - **IDLE**: on `enable`=1, go to START.
  - **START**: 1 cycle.
    - Assert `fader_start`.
    - Drive `fader_t_index`=`t_cur` (or `t_load_val` if `load_t` is high this cycle).
    - Set `t_cur` ← that value + `t_step`, mod 2^TW.
    - Load period counter with max(`period`, MIN_PERIOD)−1.
    - Set `rx_cnt`=0 and `exp_chan`=N−1.
    - Go to RUN.
  - **RUN**: the period counter decrements each cycle. On each `fader_dv`:
    - If `fader_chan`≠`exp_chan`, set `seq_err`.
    - Always increment `rx_cnt` and decrement `exp_chan`.
    - When `rx_cnt` reaches N, pulse `frame_done`, increment `frame_count`, and go to HOLD.
    - If the counter hits 0 first: set `timeout` and go to START if `enable`, else IDLE. The new start aborts the old sweep in the fader.
  - **HOLD**: `fader_dv` here sets `seq_err`. When the counter hits 0, go to START if `enable`, else IDLE.
- Deasserting `enable` never truncates a frame. The current RUN/HOLD completes; then the FSM goes to IDLE.
- `load_t` outside START: `t_cur` ← `t_load_val`.
- `fader_dv` in IDLE or START sets `seq_err`.
- `clr_status` clears `timeout`, `seq_err` and `frame_count`. A set event in the same cycle wins for flags. A `frame_count` increment in the same cycle yields 0.
- Arithmetic: `t_cur` wraps at 2^TW, unsigned. `frame_count` wraps at 2^16.

## Timing
- `enable` rising, sampled at edge k: `fader_start`=1 in cycle k+1, exactly 1 cycle wide.
- Consecutive starts are exactly P=max(`period`,MIN_PERIOD) cycles apart while `enable` stays high.
- `frame_done` is registered, 1 cycle after the N-th `fader_dv`.
- Sticky flags are registered 1 cycle after the detecting cycle.
- Asynchronous reset mid-frame: outputs drop to 0 immediately, including an in-progress `fader_start`. After `resetn` deasserts, the first start occurs 1 cycle after `enable` is sampled high.

## Structure
- Shared package `fade_pkg`:
  - `fseq_state_t` enum (IDLE, START, RUN, HOLD)
  - `FADE_M`, `FADE_N`, `FADE_TW`
  - `FADE_MIN_PERIOD`
- One sub-module, `fade_rx_check`: `rx_cnt`/`exp_chan` tracking plus `seq_err`/`frame_done` generation, fed by FSM clear strobes.
- The fader itself is instantiated only in the bench and top level.

## Test plan
- Reset, `enable`=1, `period`=300, `t_step`=5, fader model attached:
  - starts 300 cycles apart
  - `fader_t_index` = 0, 5, 10
  - 3 `frame_done` pulses, `frame_count`=3
  - `timeout`=`seq_err`=0
- `period`=100 → starts 272 cycles apart (clamped).
- Bench model emits only 31 dvs → `timeout`=1 at period expiry; next start still occurs on schedule; `frame_count` unchanged.
- Model emits chan 31, 30, 28 → `seq_err`=1. Then `clr_status` → 0, and the next clean frame leaves it 0.
- `load_t` with `t_load_val`=0x1FFFFFE coincident with START, `t_step`=3:
  - that start carries 0x1FFFFFE
  - next start carries 0x0000001 (wrap)
- `enable` dropped mid-RUN → frame completes, `frame_done` pulses, `busy`→0, no further start.
- `resetn` pulsed low mid-frame → all outputs 0 within the reset cycle.
